// File: rtl/otter_line_arb_pkg.sv
// Shared types and constants for the OTTER cache-line port arbiter.
// Optional performance counters are enabled with OTTER_LINE_ARB_PERF_EN.
package otter_line_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } grant_t;

  localparam int LINE_OFFSET_BITS = 4;
  localparam logic [31:0] IO_BASE = 32'h1100_0000;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
    logic [31:0] result;
    if (en && (value != 32'hFFFF_FFFF)) begin
      result = value + 32'd1;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/otter_line_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick between the IC and DC requesters.
module otter_rr_arb2
  import otter_line_arb_pkg::*;
(
  input  logic   req_ic,
  input  logic   req_dc,
  input  grant_t last_grant,
  output grant_t grant,
  output logic   valid
);

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant = GNT_IC;
    valid = 1'b0;
    if (req_ic && req_dc) begin
      valid = 1'b1;
      grant = (last_grant == GNT_DC) ? GNT_IC : GNT_DC;
    end else if (req_ic) begin
      valid = 1'b1;
      grant = GNT_IC;
    end else if (req_dc) begin
      valid = 1'b1;
      grant = GNT_DC;
    end else begin
      valid = 1'b0;
      grant = GNT_IC;
    end
  end

endmodule

// File: rtl/otter_line_arbiter.sv
// Shares one 128-bit memory line port between the I-cache and D-cache refill paths.
// Define OTTER_LINE_ARB_PERF_EN to add grant and stall counters.
module otter_line_arbiter
  import otter_line_arb_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128
) (
  input  logic              MEM_CLK,
  input  logic              MEM_RST,
  input  logic              IC_REQ,
  input  logic [ADDR_W-1:0] IC_ADDR,
  output logic              IC_ACK,
  output logic [LINE_W-1:0] IC_DATA,
  input  logic              DC_REQ,
  input  logic              DC_WE,
  input  logic [ADDR_W-1:0] DC_ADDR,
  input  logic [LINE_W-1:0] DC_WDATA,
  output logic              DC_ACK,
  output logic [LINE_W-1:0] DC_RDATA,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic              M_READ,
  output logic              M_WRITE,
  output logic [LINE_W-1:0] M_DIN,
  input  logic [LINE_W-1:0] M_DOUT,
  output logic              BUSY
`ifdef OTTER_LINE_ARB_PERF_EN
  ,
  output logic [31:0]       PERF_IC_GRANTS,
  output logic [31:0]       PERF_DC_GRANTS,
  output logic [31:0]       PERF_STALL
`endif
);

  localparam bit LAT_ZERO = (MEM_LAT == 32'sd0);
  localparam logic [2:0] LAT_LOAD = (MEM_LAT > 32'sd0) ? 3'(MEM_LAT - 32'sd1) : 3'd0;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((32'd1 << LINE_OFFSET_BITS) - 32'd1);

  arb_state_t        state_r;
  arb_state_t        next_state_s;
  grant_t            grant_r;
  grant_t            last_grant_r;
  grant_t            pick_s;
  logic              pick_valid_s;
  logic              we_r;
  logic [2:0]        cnt_r;
  logic [LINE_W-1:0] line_r;
  logic              start_we_s;
  logic [ADDR_W-1:0] start_addr_s;

  logic [ADDR_W-1:0] m_addr_r;
  logic              m_read_r;
  logic              m_write_r;
  logic [LINE_W-1:0] m_din_r;
  logic              ic_ack_r;
  logic              dc_ack_r;
  logic              busy_r;

  otter_rr_arb2 u_rr (
    .req_ic     (IC_REQ),
    .req_dc     (DC_REQ),
    .last_grant (last_grant_r),
    .grant      (pick_s),
    .valid      (pick_valid_s)
  );

  // Attributes of the request being granted this cycle (only used in IDLE).
  always_comb begin
    start_we_s   = 1'b0;
    start_addr_s = IC_ADDR;
    if (pick_s == GNT_DC) begin
      start_we_s   = DC_WE;
      start_addr_s = DC_ADDR;
    end else begin
      start_we_s   = 1'b0;
      start_addr_s = IC_ADDR;
    end
  end

  // Next-state logic: writes skip WAIT, reads wait out the memory latency.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) next_state_s = ACCESS;
        else              next_state_s = IDLE;
      end
      ACCESS: begin
        if (we_r || LAT_ZERO) next_state_s = DONE;
        else                  next_state_s = WAIT;
      end
      WAIT: begin
        if (cnt_r == 3'd0) next_state_s = DONE;
        else               next_state_s = WAIT;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, grant bookkeeping, latency counter and read-line capture.
  always_ff @(posedge MEM_CLK or posedge MEM_RST) begin
    if (MEM_RST) begin
      state_r      <= IDLE;
      grant_r      <= GNT_IC;
      last_grant_r <= GNT_DC;
      we_r         <= 1'b0;
      cnt_r        <= 3'd0;
      line_r       <= '0;
    end else begin
      state_r <= next_state_s;
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            grant_r      <= pick_s;
            last_grant_r <= pick_s;
            we_r         <= start_we_s;
          end
        end
        ACCESS: begin
          if (!we_r) begin
            if (LAT_ZERO) line_r <= M_DOUT;
            else          cnt_r  <= LAT_LOAD;
          end
        end
        WAIT: begin
          if (cnt_r == 3'd0) line_r <= M_DOUT;
          else               cnt_r  <= cnt_r - 3'd1;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Outputs are registered and decoded from the state being entered.
  always_ff @(posedge MEM_CLK or posedge MEM_RST) begin
    if (MEM_RST) begin
      m_addr_r  <= '0;
      m_read_r  <= 1'b0;
      m_write_r <= 1'b0;
      m_din_r   <= '0;
      ic_ack_r  <= 1'b0;
      dc_ack_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      m_read_r  <= ((next_state_s == ACCESS) && !start_we_s) || (next_state_s == WAIT);
      m_write_r <= (next_state_s == ACCESS) && start_we_s;
      m_din_r   <= ((next_state_s == ACCESS) && start_we_s) ? DC_WDATA : '0;
      if (next_state_s == ACCESS) m_addr_r <= start_addr_s & LINE_MASK;
      else                        m_addr_r <= m_addr_r;
      ic_ack_r  <= (next_state_s == DONE) && (grant_r == GNT_IC);
      dc_ack_r  <= (next_state_s == DONE) && (grant_r == GNT_DC);
      busy_r    <= (next_state_s != IDLE);
    end
  end

  assign M_ADDR   = m_addr_r;
  assign M_READ   = m_read_r;
  assign M_WRITE  = m_write_r;
  assign M_DIN    = m_din_r;
  assign IC_ACK   = ic_ack_r;
  assign DC_ACK   = dc_ack_r;
  assign IC_DATA  = line_r;
  assign DC_RDATA = line_r;
  assign BUSY     = busy_r;

`ifdef OTTER_LINE_ARB_PERF_EN
  logic [31:0] perf_ic_r;
  logic [31:0] perf_dc_r;
  logic [31:0] perf_stall_r;
  logic        ic_gnt_evt_s;
  logic        dc_gnt_evt_s;
  logic        stall_evt_s;

  // A requester stalls whenever its REQ is up and it is not being acknowledged.
  always_comb begin
    ic_gnt_evt_s = (state_r == IDLE) && pick_valid_s && (pick_s == GNT_IC);
    dc_gnt_evt_s = (state_r == IDLE) && pick_valid_s && (pick_s == GNT_DC);
    stall_evt_s  = (IC_REQ && !((state_r == DONE) && (grant_r == GNT_IC))) ||
                   (DC_REQ && !((state_r == DONE) && (grant_r == GNT_DC)));
  end

  // Saturating performance counters.
  always_ff @(posedge MEM_CLK or posedge MEM_RST) begin
    if (MEM_RST) begin
      perf_ic_r    <= 32'd0;
      perf_dc_r    <= 32'd0;
      perf_stall_r <= 32'd0;
    end else begin
      perf_ic_r    <= sat_inc(perf_ic_r, ic_gnt_evt_s);
      perf_dc_r    <= sat_inc(perf_dc_r, dc_gnt_evt_s);
      perf_stall_r <= sat_inc(perf_stall_r, stall_evt_s);
    end
  end

  assign PERF_IC_GRANTS = perf_ic_r;
  assign PERF_DC_GRANTS = perf_dc_r;
  assign PERF_STALL     = perf_stall_r;
`endif

endmodule
